// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC, imem req/ready fetch and the
// instruction register presented to decode/execute.
module pc_fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            commit,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instret,
  output logic            misalign_err
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    EXEC,
    ERROR
  } state_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  localparam logic [XLEN-1:0] ONE = XLEN'(1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t state, state_nx;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instret_q;
  logic [XLEN-1:0] next_pc;
  logic [31:0]     inst_q;
  logic            valid_q;
  logic            err_q;
  logic            fetch_done;
  logic            commit_ok;
  logic            commit_bad;

  always_comb begin
    next_pc = pc_q + FOUR;
    unique case (pc_sel)
      2'd1:    next_pc = pc_q + imm;
      2'd2:    next_pc = {alu_result[XLEN-1:1], 1'b0};
      default: next_pc = pc_q + FOUR;
    endcase
  end

  always_comb begin
    state_nx   = state;
    imem_req   = 1'b0;
    fetch_done = 1'b0;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    unique case (state)
      BOOT: state_nx = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          fetch_done = 1'b1;
          state_nx   = EXEC;
        end
      end
      EXEC: begin
        if (commit) begin
          // a misaligned target never reaches pc
          if (next_pc[1:0] == 2'b00) begin
            commit_ok = 1'b1;
            state_nx  = FETCH;
          end else begin
            commit_bad = 1'b1;
            state_nx   = ERROR;
          end
        end
      end
      ERROR:   state_nx = ERROR;
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= NOP;
      valid_q   <= 1'b0;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (fetch_done) begin
        inst_q  <= imem_rdata;
        valid_q <= 1'b1;
      end
      if (commit_ok) begin
        pc_q      <= next_pc;
        instret_q <= instret_q + ONE;
        valid_q   <= 1'b0;
      end
      if (commit_bad) begin
        err_q   <= 1'b1;
        valid_q <= 1'b0;
      end
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + FOUR;
  assign inst         = inst_q;
  assign inst_valid   = valid_q;
  assign instret      = instret_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors for pc_fetch_unit with
// hand-computed expectations.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  pc_sel = 2'd0;
  logic [31:0] imm = '0;
  logic [31:0] alu_result = '0;
  logic        commit = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instret;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_sel(pc_sel),
    .imm(imm),
    .alu_result(alu_result),
    .commit(commit),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst(inst),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .instret(instret),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    imem_ready = 1'b1;
    imem_rdata = w;
    step();
    imem_ready = 1'b0;
  endtask

  task automatic retire(input logic [1:0] s,
                        input logic [31:0] i,
                        input logic [31:0] a);
    pc_sel = s;
    imm = i;
    alu_result = a;
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_inst"}, inst, 32'h0000_0013);
    check({tag, "_valid"}, 32'(inst_valid), 32'h0);
    check({tag, "_ret"}, instret, 32'h0);
    check({tag, "_err"}, 32'(misalign_err), 32'h0);
    check({tag, "_req"}, 32'(imem_req), 32'h0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2 check_reset("rst");
    step();
    step();
    rst_n = 1'b1;
    check("boot_req", 32'(imem_req), 32'h0);
    step();
    check("boot_to_fetch", 32'(imem_req), 32'h1);

    // back-to-back: ready and commit held high in every state
    imem_ready = 1'b1;
    commit = 1'b1;
    pc_sel = 2'd0;
    for (int k = 0; k < 3; k++) begin
      imem_rdata = 32'hA000_0000 + 32'(k);
      check($sformatf("seq_addr%0d", k), imem_addr, 32'(4 * k));
      check($sformatf("seq_req%0d", k), 32'(imem_req), 32'h1);
      step();
      check($sformatf("seq_inst%0d", k), inst, 32'hA000_0000 + 32'(k));
      check($sformatf("seq_exreq%0d", k), 32'(imem_req), 32'h0);
      check($sformatf("seq_plus4_%0d", k), pc_plus4, 32'(4 * k + 4));
      step();
      check($sformatf("seq_ret%0d", k), instret, 32'(k + 1));
      check($sformatf("seq_val%0d", k), 32'(inst_valid), 32'h0);
    end
    imem_ready = 1'b0;
    commit = 1'b0;

    // memory wait states
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("wait_req%0d", k), 32'(imem_req), 32'h1);
      check($sformatf("wait_addr%0d", k), imem_addr, 32'h0000_000C);
      check($sformatf("wait_val%0d", k), 32'(inst_valid), 32'h0);
    end
    fetch(32'h1111_1111);
    check("wait_inst", inst, 32'h1111_1111);
    check("wait_valid", 32'(inst_valid), 32'h1);

    // held-off commit keeps the instruction
    step();
    step();
    check("hold_valid", 32'(inst_valid), 32'h1);
    check("hold_ret", instret, 32'h3);

    // jalr target with LSB set is cleared
    retire(2'd2, 32'h0, 32'h0000_0301);
    check("jalr_pc", pc, 32'h0000_0300);
    check("jalr_ret", instret, 32'h4);
    check("jalr_err", 32'(misalign_err), 32'h0);

    fetch(32'h2);
    retire(2'd2, 32'h0, 32'h0000_0100);
    check("to100", pc, 32'h0000_0100);

    // negative branch offset
    fetch(32'h3);
    retire(2'd1, 32'hFFFF_FFF0, 32'h0);
    check("br_addr", imem_addr, 32'h0000_00F0);
    check("br_ret", instret, 32'h6);

    // pc wrap at top of address space
    fetch(32'h4);
    retire(2'd2, 32'h0, 32'hFFFF_FFFC);
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_plus4", pc_plus4, 32'h0);
    fetch(32'h5);
    retire(2'd0, 32'h0, 32'h0);
    check("wrap_pc", pc, 32'h0);
    fetch(32'h6);
    retire(2'd3, 32'h40, 32'h80);
    check("sel3_pc", pc, 32'h4);
    check("sel3_ret", instret, 32'h9);

    // alu 0x205 clears to aligned 0x204
    fetch(32'h7);
    retire(2'd2, 32'h0, 32'h0000_0205);
    check("j205_pc", pc, 32'h0000_0204);
    check("j205_err", 32'(misalign_err), 32'h0);

    // misaligned branch target
    fetch(32'h8);
    retire(2'd1, 32'h2, 32'h0);
    check("mis_err", 32'(misalign_err), 32'h1);
    check("mis_pc", pc, 32'h0000_0204);
    check("mis_ret", instret, 32'hA);
    check("mis_val", 32'(inst_valid), 32'h0);
    imem_ready = 1'b1;
    commit = 1'b1;
    step();
    step();
    check("err_req", 32'(imem_req), 32'h0);
    check("err_hold", 32'(misalign_err), 32'h1);
    check("err_val", 32'(inst_valid), 32'h0);
    imem_ready = 1'b0;
    commit = 1'b0;

    // reset out of ERROR
    rst_n = 1'b0;
    #1 check_reset("rst_err");
    step();
    rst_n = 1'b1;
    step();
    check("re_req", 32'(imem_req), 32'h1);
    check("re_addr", imem_addr, 32'h0);

    // reset mid-fetch, late response ignored
    step();
    #2 rst_n = 1'b0;
    #1 check("mid_req", 32'(imem_req), 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    rst_n = 1'b1;
    step();
    check("late_inst", inst, 32'h0000_0013);
    check("late_val", 32'(inst_valid), 32'h0);
    check("late_req", 32'(imem_req), 32'h1);
    step();
    check("refetch_inst", inst, 32'hDEAD_BEEF);
    check("refetch_val", 32'(inst_valid), 32'h1);
    imem_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
